rib_uart_dump: RTL
==================

Name: rib_uart_dump

Overview:
- RIB read master that streams a block of memory out over UART TX. It is the readback counterpart of the UART program loader.
- Given a start pulse, a base address and a word count, it reads words one at a time over a RIB master read port. It transmits each word as 4 bytes, LSB first, in 8N1 format.
- It occupies a spare RIB master slot, normally m2, so host software can verify ROM/RAM contents after download.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, UART bit rate.
- BAUD_DIV, CLK_FREQ/BAUD_RATE (integer division, 434 at defaults), clock cycles per UART bit. Derived localparam.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- start_i  in  1  single-cycle start pulse
- base_addr_i  in  32  first byte address, sampled on accepted start
- word_cnt_i  in  16  number of 32-bit words to dump, sampled on accepted start
- rd_req_o  out  1  RIB read request
- rd_addr_o  out  32  RIB read address
- rd_gnt_i  in  1  RIB grant; rd_data_i is valid in the same cycle
- rd_data_i  in  32  RIB read data
- uart_tx  out  1  UART serial output, idle high
- busy_o  out  1  high from accepted start until the done pulse
- done_o  out  1  one-cycle pulse when the dump completes

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State IDLE.
  - rd_req_o=0, rd_addr_o=0, uart_tx=1, busy_o=0, done_o=0.
  - All counters 0.
  - Reset mid-frame drives uart_tx high at once and abandons the dump. No resume.
- IDLE:
  - start_i=1 latches base_addr_i into the address register and word_cnt_i into the remaining-count register.
  - busy_o rises the next cycle.
  - If word_cnt_i==0, go to DONE; no RIB access, no UART activity.
  - Otherwise go to REQ.
  - start_i in any state other than IDLE is ignored.
- REQ:
  - rd_req_o=1; rd_addr_o = address register.
  - Both are held stable until rd_gnt_i=1.
  - On the grant cycle: capture rd_data_i into the shift word, drop rd_req_o on the next cycle, set byte counter to 0, go to TX_START.
  - No timeout; a request stalls indefinitely without a grant.
- TX_START: uart_tx=0 for BAUD_DIV cycles.
- TX_DATA:
  - Sends bits 0..7 of the current byte, LSB first, BAUD_DIV cycles each.
  - The byte is word[8*k+7:8*k] for byte index k.
  - Bit counter is 3 bits.
- TX_STOP:
  - uart_tx=1 for BAUD_DIV cycles.
  - If byte index < 3: increment it and go to TX_START.
  - Otherwise go to NEXT.
- NEXT (one cycle):
  - Address += 4, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
  - Remaining count -= 1.
  - If the result is 0, go to DONE; otherwise go to REQ.
- DONE (one cycle): done_o=1, busy_o falls on the same edge, then return to IDLE.
- Baud counter:
  - Counts 0..BAUD_DIV-1 and is reset on every state entry into TX_START, TX_DATA bit change and TX_STOP.
  - A bit period is exactly BAUD_DIV cycles.
  - There is no inter-byte gap beyond the stop bit.
- Timing:
  - Frame = 10*BAUD_DIV cycles; word = 40*BAUD_DIV cycles.
  - Per word, overhead = grant latency + 1 cycle REQ exit + 1 cycle NEXT.
- uart_tx is registered and free of glitches.
- rd_addr_o holds its last value when not requesting.

Test Plan:
- Single word: base 0x00000000, count 1, slave returns 0x12345678 with grant on the first REQ cycle.
  - rd_req_o is high for exactly 1 cycle at address 0x0.
  - uart_tx bytes decode as 0x78, 0x56, 0x34, 0x12, each bit 434 cycles wide.
  - done_o pulses once; busy_o is low afterwards.
- Grant stall: hold rd_gnt_i low for 5 cycles.
  - rd_req_o stays high and rd_addr_o stays stable for 6 cycles.
  - uart_tx stays 1 until after the grant.
  - Data captured is the value present on the grant cycle.
- Multi-word with wrap: base 0xFFFFFFFC, count 2.
  - Read addresses are 0xFFFFFFFC then 0x00000000.
  - 8 bytes are transmitted in order; a single done_o pulse.
- Zero count: start with count 0.
  - done_o pulses 2 cycles after start.
  - rd_req_o never asserts; uart_tx stays 1.
- Start while busy: a second start_i pulse mid-frame with a different base.
  - It is ignored; the original address sequence and byte stream are unchanged.
- Reset mid-frame: assert rst during a data bit of byte 2.
  - uart_tx goes 1, rd_req_o and busy_o go 0 immediately.
  - A fresh start after release dumps correctly from the new base.

Source files
------------

// File: rtl/rib_uart_dump.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rib_uart_dump                                                     |
// | Brief  : RIB read master that streams a block of words out over 8N1 UART.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module rib_uart_dump #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [15:0] word_cnt_i,
    output logic        rd_req_o,
    output logic [31:0] rd_addr_o,
    input  logic        rd_gnt_i,
    input  logic [31:0] rd_data_i,
    output logic        uart_tx,
    output logic        busy_o,
    output logic        done_o
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int c_BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(BAUD_DIV - 1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_REQ      = 3'd1;
    localparam logic [2:0] c_TX_START = 3'd2;
    localparam logic [2:0] c_TX_DATA  = 3'd3;
    localparam logic [2:0] c_TX_STOP  = 3'd4;
    localparam logic [2:0] c_NEXT     = 3'd5;
    localparam logic [2:0] c_DONE     = 3'd6;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [31:0]         r_addr;
    logic [15:0]         r_remain;
    logic [31:0]         r_word;
    logic [1:0]          r_byte_idx;
    logic [2:0]          r_bit_idx;
    logic [c_BAUD_W-1:0] r_baud;
    logic                r_req;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;
    logic                w_baud_end;
    logic [2:0]          w_bit_inc;

    assign w_baud_end = (r_baud == c_BAUD_LAST);
    assign w_bit_inc  = r_bit_idx + 3'd1;

    assign rd_req_o  = r_req;
    assign rd_addr_o = r_addr;
    assign uart_tx   = r_tx;
    assign busy_o    = r_busy;
    assign done_o    = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:     if (start_i) w_state_next = (word_cnt_i == 16'd0) ? c_DONE : c_REQ;
            c_REQ:      if (rd_gnt_i) w_state_next = c_TX_START;
            c_TX_START: if (w_baud_end) w_state_next = c_TX_DATA;
            c_TX_DATA:  if (w_baud_end && (r_bit_idx == 3'd7)) w_state_next = c_TX_STOP;
            c_TX_STOP:  if (w_baud_end) w_state_next = (r_byte_idx == 2'd3) ? c_NEXT : c_TX_START;
            c_NEXT:     w_state_next = (r_remain == 16'd1) ? c_DONE : c_REQ;
            c_DONE:     w_state_next = c_IDLE;
            default:    w_state_next = c_IDLE;
        endcase
    end

    // uart_tx is loaded with the level of the state being entered so the line is registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= 32'd0;
            r_remain   <= 16'd0;
            r_word     <= 32'd0;
            r_byte_idx <= 2'd0;
            r_bit_idx  <= 3'd0;
            r_baud     <= '0;
            r_req      <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == c_DONE);
            case (r_state)
                c_IDLE: begin
                    if (start_i) begin
                        r_addr   <= base_addr_i;
                        r_remain <= word_cnt_i;
                        r_busy   <= 1'b1;
                        r_req    <= (word_cnt_i != 16'd0);
                    end
                end
                c_REQ: begin
                    if (rd_gnt_i) begin
                        r_word     <= rd_data_i;
                        r_req      <= 1'b0;
                        r_byte_idx <= 2'd0;
                        r_baud     <= '0;
                        r_tx       <= 1'b0;
                    end
                end
                c_TX_START: begin
                    if (w_baud_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_word[{r_byte_idx, 3'd0}];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                c_TX_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx <= 1'b1;
                        end else begin
                            r_bit_idx <= w_bit_inc;
                            r_tx      <= r_word[{r_byte_idx, w_bit_inc}];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                c_TX_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_byte_idx != 2'd3) begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_tx       <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                c_NEXT: begin
                    r_addr   <= r_addr + 32'd4;
                    r_remain <= r_remain - 16'd1;
                    r_req    <= (r_remain != 16'd1);
                end
                c_DONE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_req <= 1'b0;
                    r_tx  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
